// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_pkg
// Purpose  : Shared types and helpers for the load/store unit: FSM state
//            encoding, RV32I load/store funct3 codes, funct3 legality and
//            access-size decoding.
// Revision : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ0 = 3'd1,
        S_RSP0 = 3'd2,
        S_REQ1 = 3'd3,
        S_RSP1 = 3'd4,
        S_DONE = 3'd5
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants exist only for loads.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Access size in bytes from funct3[1:0]; code 3 is illegal and never
    // reaches memory, so it simply decodes as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            2'd0:    n = 3'd1;
            2'd1:    n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Combinational lane logic for the load/store unit. Produces the
//            per-beat byte enables and lane-shifted write data, and extracts
//            and sign/zero-extends the load result from the two beat buffers.
// Ports    : i_size     - funct3[1:0] (0 byte, 1 half, 2 word)
//            i_off      - byte offset within the first word
//            i_unsigned - funct3[2], zero-extend when set
//            i_wdata    - LSB-justified store data
//            i_buf0/1   - read data captured for beat 0 / beat 1
//            o_be0/1    - byte enables for beat 0 / beat 1
//            o_wdata0/1 - lane-aligned write data for beat 0 / beat 1
//            o_rdata    - extended load result
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align (
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_buf0,
    input  logic [31:0] i_buf1,
    output logic [3:0]  o_be0,
    output logic [3:0]  o_be1,
    output logic [31:0] o_wdata0,
    output logic [31:0] o_wdata1,
    output logic [31:0] o_rdata
);
    import load_store_unit_pkg::*;

    logic [3:0]  w_mask4;
    logic [7:0]  w_mask8;
    logic [63:0] w_w64;
    logic [31:0] w_r32;

    always_comb begin
        case (size_bytes(i_size))
            3'd1:    w_mask4 = 4'b0001;
            3'd2:    w_mask4 = 4'b0011;
            default: w_mask4 = 4'b1111;
        endcase
    end

    // A two-word window: lanes past byte 3 spill into the second beat.
    assign w_mask8  = {4'b0000, w_mask4} << i_off;
    assign o_be0    = w_mask8[3:0];
    assign o_be1    = w_mask8[7:4];

    assign w_w64    = {32'b0, i_wdata} << {i_off, 3'b000};
    assign o_wdata0 = w_w64[31:0];
    assign o_wdata1 = w_w64[63:32];

    // Only the low word of the shifted window can hold the result.
    assign w_r32    = 32'({i_buf1, i_buf0} >> {i_off, 3'b000});

    always_comb begin
        case (i_size)
            2'd0:    o_rdata = i_unsigned ? {24'b0, w_r32[7:0]}
                                          : {{24{w_r32[7]}}, w_r32[7:0]};
            2'd1:    o_rdata = i_unsigned ? {16'b0, w_r32[15:0]}
                                          : {{16{w_r32[15]}}, w_r32[15:0]};
            default: o_rdata = w_r32;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Multi-cycle RV32I load/store engine between the execute stage
//            and a word-addressed data RAM. Word-crossing accesses are split
//            into two beats when ALLOW_MISALIGNED is set, otherwise they
//            fault without touching memory.
// Ports    : clk, clk_en, rst                - clock, enable, sync reset
//            i_req/i_is_store/i_funct3/
//            i_addr/i_wdata                  - access command (IDLE only)
//            o_busy/o_done/o_fault/o_rdata   - core-side status and result
//            o_mem_req/we/addr/be/wdata,
//            i_mem_ready/rvalid/rdata        - RAM request/response channel
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_WIDTH       = 31,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  clk_en,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic                  i_is_store,
    input  logic [2:0]            i_funct3,
    input  logic [31:0]           i_addr,
    input  logic [31:0]           i_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_fault,
    output logic [31:0]           o_rdata,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH:0]   o_mem_addr,
    output logic [3:0]            o_mem_be,
    output logic [31:0]           o_mem_wdata,
    input  logic                  i_mem_ready,
    input  logic                  i_mem_rvalid,
    input  logic [31:0]           i_mem_rdata
);
    import load_store_unit_pkg::*;

    localparam int AW = ADDR_WIDTH + 1;

    lsu_state_e  r_state;
    lsu_state_e  w_next;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_fault;
    logic [31:0] r_buf0;
    logic [31:0] r_buf1;
    logic [31:0] r_rdata;

    logic        w_in_misal;
    logic        w_in_fault;
    logic        w_split;
    logic        w_req;
    logic        w_beat1;
    logic        w_ld_done;
    logic [29:0] w_word;
    logic [ADDR_WIDTH:0] w_addr_out;
    logic [3:0]  w_be0;
    logic [3:0]  w_be1;
    logic [31:0] w_wd0;
    logic [31:0] w_wd1;
    logic [31:0] w_ld_data;

    // Fault decision is made on the raw command so a faulting access never
    // enters a request state.
    assign w_in_misal = (i_funct3[1:0] == 2'd1 && i_addr[0]) ||
                        (i_funct3[1:0] == 2'd2 && i_addr[1:0] != 2'b00);
    assign w_in_fault = ~f3_legal(i_is_store, i_funct3) ||
                        (~ALLOW_MISALIGNED && w_in_misal);

    assign w_split    = ({1'b0, r_addr[1:0]} + size_bytes(r_funct3[1:0])) > 3'd4;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_req) w_next = w_in_fault ? S_DONE : S_REQ0;
            S_REQ0: if (i_mem_ready) begin
                        if (!r_is_store) w_next = S_RSP0;
                        else             w_next = w_split ? S_REQ1 : S_DONE;
                    end
            S_RSP0: if (i_mem_rvalid) w_next = w_split ? S_REQ1 : S_DONE;
            S_REQ1: if (i_mem_ready) w_next = r_is_store ? S_DONE : S_RSP1;
            S_RSP1: if (i_mem_rvalid) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_is_store <= 1'b0;
            r_funct3   <= 3'b000;
            r_addr     <= 32'b0;
            r_wdata    <= 32'b0;
            r_fault    <= 1'b0;
            r_buf0     <= 32'b0;
            r_buf1     <= 32'b0;
            r_rdata    <= 32'b0;
        end else if (clk_en) begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_req) begin
                r_is_store <= i_is_store;
                r_funct3   <= i_funct3;
                r_addr     <= i_addr;
                r_wdata    <= i_wdata;
                r_fault    <= w_in_fault;
            end
            if (r_state == S_RSP0 && i_mem_rvalid) r_buf0 <= i_mem_rdata;
            if (r_state == S_RSP1 && i_mem_rvalid) r_buf1 <= i_mem_rdata;
            if (w_ld_done) r_rdata <= w_ld_data;
        end
    end

    lsu_align u_align (
        .i_size     (r_funct3[1:0]),
        .i_off      (r_addr[1:0]),
        .i_unsigned (r_funct3[2]),
        .i_wdata    (r_wdata),
        .i_buf0     (r_buf0),
        .i_buf1     (r_buf1),
        .o_be0      (w_be0),
        .o_be1      (w_be1),
        .o_wdata0   (w_wd0),
        .o_wdata1   (w_wd1),
        .o_rdata    (w_ld_data)
    );

    assign w_req     = (r_state == S_REQ0) || (r_state == S_REQ1);
    assign w_beat1   = (r_state == S_REQ1);
    assign w_ld_done = (r_state == S_DONE) && !r_is_store && !r_fault;

    // Second beat targets the next word; 30-bit arithmetic wraps naturally.
    assign w_word    = w_beat1 ? (r_addr[31:2] + 30'd1) : r_addr[31:2];

    generate
        if (AW > 30) begin : g_addr_ext
            assign w_addr_out = {{(AW - 30){1'b0}}, w_word};
        end else if (AW == 30) begin : g_addr_eq
            assign w_addr_out = w_word;
        end else begin : g_addr_trunc
            assign w_addr_out = w_word[AW-1:0];
        end
    endgenerate

    assign o_mem_req   = w_req;
    assign o_mem_we    = w_req && r_is_store;
    assign o_mem_addr  = w_req ? w_addr_out : '0;
    assign o_mem_be    = w_req ? (w_beat1 ? w_be1 : w_be0) : 4'b0000;
    assign o_mem_wdata = (w_req && r_is_store) ? (w_beat1 ? w_wd1 : w_wd0) : 32'b0;

    assign o_busy  = (r_state != S_IDLE);
    assign o_done  = (r_state == S_DONE);
    assign o_fault = (r_state == S_DONE) && r_fault;
    // The new result is visible in the completion cycle itself.
    assign o_rdata = w_ld_done ? w_ld_data : r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit. Directed accesses push
//            their expected RAM beats and completion into a queue; a monitor
//            pops and compares whenever the DUT presents a request or o_done.
//            A second instance with ALLOW_MISALIGNED=0 covers alignment faults.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic        i_req2 = 1'b0;
    logic        i_is_store = 1'b0;
    logic [2:0]  i_funct3 = 3'b0;
    logic [31:0] i_addr = 32'b0;
    logic [31:0] i_wdata = 32'b0;
    logic        o_busy, o_done, o_fault, o_mem_req, o_mem_we;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_ready = 1'b1;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = 32'b0;

    logic        o_busy2, o_done2, o_fault2, o_mem_req2, o_mem_we2;
    logic [31:0] o_rdata2, o_mem_addr2, o_mem_wdata2;
    logic [3:0]  o_mem_be2;
    logic        i_mem_ready2 = 1'b1;
    logic        i_mem_rvalid2 = 1'b0;
    logic [31:0] i_mem_rdata2 = 32'b0;

    load_store_unit #(.ADDR_WIDTH(31), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .clk_en(clk_en), .rst(rst),
        .i_req(i_req), .i_is_store(i_is_store), .i_funct3(i_funct3),
        .i_addr(i_addr), .i_wdata(i_wdata),
        .o_busy(o_busy), .o_done(o_done), .o_fault(o_fault), .o_rdata(o_rdata),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
        .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    load_store_unit #(.ADDR_WIDTH(31), .ALLOW_MISALIGNED(1'b0)) dut_strict (
        .clk(clk), .clk_en(clk_en), .rst(rst),
        .i_req(i_req2), .i_is_store(i_is_store), .i_funct3(i_funct3),
        .i_addr(i_addr), .i_wdata(i_wdata),
        .o_busy(o_busy2), .o_done(o_done2), .o_fault(o_fault2), .o_rdata(o_rdata2),
        .o_mem_req(o_mem_req2), .o_mem_we(o_mem_we2), .o_mem_addr(o_mem_addr2),
        .o_mem_be(o_mem_be2), .o_mem_wdata(o_mem_wdata2),
        .i_mem_ready(i_mem_ready2), .i_mem_rvalid(i_mem_rvalid2), .i_mem_rdata(i_mem_rdata2)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [31:0] addr;
        logic [3:0]  be;
        bit          we;
        logic [31:0] wdata;
        bit          fault;
        logic [31:0] rdata;
        bit          chk_rdata;
        int          lat;
    } exp_t;

    exp_t q[$];
    logic [31:0] mem [logic [31:0]];
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int issue_cyc = 0;
    int stall_left = 0;
    bit force_rvalid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_req(input logic [31:0] a, input logic [3:0] be, input bit we, input logic [31:0] wd);
        exp_t e;
        e = '{is_done: 1'b0, addr: a, be: be, we: we, wdata: wd,
              fault: 1'b0, rdata: 32'b0, chk_rdata: 1'b0, lat: 0};
        q.push_back(e);
    endtask

    task automatic push_done(input bit f, input logic [31:0] rd, input bit crd, input int lat);
        exp_t e;
        e = '{is_done: 1'b1, addr: 32'b0, be: 4'b0, we: 1'b0, wdata: 32'b0,
              fault: f, rdata: rd, chk_rdata: crd, lat: lat};
        q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // RAM model: request accepted at an edge returns read data the next cycle.
    initial begin
        bit hs, hwe;
        logic [31:0] ha, hwd, w;
        logic [3:0] hbe;
        forever begin
            @(negedge clk);
            hs = o_mem_req && i_mem_ready && !rst;
            hwe = o_mem_we; ha = o_mem_addr; hbe = o_mem_be; hwd = o_mem_wdata;
            @(posedge clk); #1;
            i_mem_rvalid = force_rvalid;
            if (hs && !hwe) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata = mem.exists(ha) ? mem[ha] : 32'b0;
            end
            if (hs && hwe) begin
                w = mem.exists(ha) ? mem[ha] : 32'b0;
                for (int b = 0; b < 4; b++)
                    if (hbe[b]) w[8*b +: 8] = hwd[8*b +: 8];
                mem[ha] = w;
            end
            if (o_mem_req && stall_left > 0) begin
                i_mem_ready = 1'b0;
                stall_left--;
            end else begin
                i_mem_ready = 1'b1;
            end
        end
    end

    // Monitor: compares every presented request (including stalled cycles)
    // and every completion against the head of the expectation queue.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (o_mem_req) begin
                if (q.size() == 0 || q[0].is_done) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_mem_req: got addr 0x%08h expected no request", o_mem_addr);
                end else begin
                    chk("mem_addr", o_mem_addr, q[0].addr);
                    chk("mem_be", {28'b0, o_mem_be}, {28'b0, q[0].be});
                    chk("mem_we", {31'b0, o_mem_we}, {31'b0, q[0].we});
                    if (q[0].we) chk("mem_wdata", o_mem_wdata, q[0].wdata);
                    if (i_mem_ready) void'(q.pop_front());
                end
            end
            if (o_done) begin
                if (q.size() == 0 || !q[0].is_done) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_done: got o_done=1 expected no completion");
                end else begin
                    chk("fault", {31'b0, o_fault}, {31'b0, q[0].fault});
                    if (q[0].chk_rdata) chk("rdata", o_rdata, q[0].rdata);
                    chk("latency", 32'(cyc - issue_cyc), 32'(q[0].lat));
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        i_is_store = st; i_funct3 = f3; i_addr = a; i_wdata = wd;
        i_req = 1'b1; issue_cyc = cyc;
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            seen = o_done;
        end
        if (!seen) begin
            n_chk++; n_fail++;
            $display("FAIL done_timeout: got no o_done expected o_done within 60 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic run(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        issue(st, f3, a, wd);
        wait_done();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'b0, o_busy}, 32'd0);
        chk("rst_done", {31'b0, o_done}, 32'd0);
        chk("rst_mem_req", {31'b0, o_mem_req}, 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);
        chk("rst_mem_be", {28'b0, o_mem_be}, 32'd0);
        @(posedge clk); #1;

        // Aligned word load.
        mem[32'h40] = 32'hDEADBEEF;
        push_req(32'h40, 4'b1111, 1'b0, 32'b0);
        push_done(1'b0, 32'hDEADBEEF, 1'b1, 3);
        run(1'b0, F3_W, 32'h100, 32'b0);

        // Split word load across 0x40/0x41.
        mem[32'h40] = 32'h11223344;
        mem[32'h41] = 32'h55667788;
        push_req(32'h40, 4'b1000, 1'b0, 32'b0);
        push_req(32'h41, 4'b0111, 1'b0, 32'b0);
        push_done(1'b0, 32'h66778811, 1'b1, 5);
        run(1'b0, F3_W, 32'h103, 32'b0);

        // Split halfword store.
        push_req(32'h41, 4'b1000, 1'b1, 32'hCD000000);
        push_req(32'h42, 4'b0001, 1'b1, 32'h000000AB);
        push_done(1'b0, 32'b0, 1'b0, 3);
        run(1'b1, F3_H, 32'h107, 32'h0000ABCD);

        // Read back both words touched by the split store.
        push_req(32'h41, 4'b1111, 1'b0, 32'b0);
        push_done(1'b0, 32'hCD667788, 1'b1, 3);
        run(1'b0, F3_W, 32'h104, 32'b0);
        push_req(32'h42, 4'b0011, 1'b0, 32'b0);
        push_done(1'b0, 32'h000000AB, 1'b1, 3);
        run(1'b0, F3_HU, 32'h108, 32'b0);

        // Signed byte with three ready-low cycles, then unsigned byte.
        mem[32'h40] = 32'h0080FF00;
        stall_left = 3;
        push_req(32'h40, 4'b0100, 1'b0, 32'b0);
        push_done(1'b0, 32'hFFFFFF80, 1'b1, 6);
        run(1'b0, F3_B, 32'h102, 32'b0);
        push_req(32'h40, 4'b0100, 1'b0, 32'b0);
        push_done(1'b0, 32'h00000080, 1'b1, 3);
        run(1'b0, F3_BU, 32'h102, 32'b0);

        // Misaligned but non-crossing signed halfword.
        push_req(32'h40, 4'b0110, 1'b0, 32'b0);
        push_done(1'b0, 32'hFFFF80FF, 1'b1, 3);
        run(1'b0, F3_H, 32'h101, 32'b0);

        // Word store, byte store into lane 1, signed halfword read-back.
        push_req(32'h80, 4'b1111, 1'b1, 32'h12345678);
        push_done(1'b0, 32'b0, 1'b0, 2);
        run(1'b1, F3_W, 32'h200, 32'h12345678);
        push_req(32'h80, 4'b0010, 1'b1, 32'h0000EE00);
        push_done(1'b0, 32'b0, 1'b0, 2);
        run(1'b1, F3_B, 32'h201, 32'h000000EE);
        push_req(32'h80, 4'b0011, 1'b0, 32'b0);
        push_done(1'b0, 32'hFFFFEE78, 1'b1, 3);
        run(1'b0, F3_H, 32'h200, 32'b0);

        // Split load at the top of the address space wraps to word 0.
        mem[32'h3FFFFFFF] = 32'hAABBCCDD;
        mem[32'h0] = 32'h11223344;
        push_req(32'h3FFFFFFF, 4'b1100, 1'b0, 32'b0);
        push_req(32'h0, 4'b0011, 1'b0, 32'b0);
        push_done(1'b0, 32'h3344AABB, 1'b1, 5);
        run(1'b0, F3_W, 32'hFFFFFFFE, 32'b0);

        // Illegal funct3 for load (3) and store (4): fault, no RAM access.
        push_done(1'b1, 32'b0, 1'b0, 1);
        run(1'b0, 3'd3, 32'h100, 32'b0);
        push_done(1'b1, 32'b0, 1'b0, 1);
        run(1'b1, F3_BU, 32'h100, 32'b0);

        // Strict instance: misaligned word load faults at c1 with no request.
        i_is_store = 1'b0; i_funct3 = F3_W; i_addr = 32'h102;
        i_req2 = 1'b1;
        @(negedge clk);
        chk("strict_c0_mem_req", {31'b0, o_mem_req2}, 32'd0);
        @(posedge clk); #1;
        i_req2 = 1'b0;
        @(negedge clk);
        chk("strict_c1_done", {31'b0, o_done2}, 32'd1);
        chk("strict_c1_fault", {31'b0, o_fault2}, 32'd1);
        chk("strict_c1_mem_req", {31'b0, o_mem_req2}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("strict_c2_done", {31'b0, o_done2}, 32'd0);
        @(posedge clk); #1;

        // Reset after beat 0 of a split load is accepted.
        push_req(32'h40, 4'b1000, 1'b0, 32'b0);
        issue(1'b0, F3_W, 32'h103, 32'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        force_rvalid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        force_rvalid = 1'b0;
        chk("rstmid_mem_req", {31'b0, o_mem_req}, 32'd0);
        chk("rstmid_busy", {31'b0, o_busy}, 32'd0);
        chk("rstmid_rdata", o_rdata, 32'd0);
        chk("rstmid_done", {31'b0, o_done}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("rstmid_queue", 32'(q.size()), 32'd0);

        // Recovery after reset.
        push_req(32'h40, 4'b1111, 1'b0, 32'b0);
        push_done(1'b0, 32'h0080FF00, 1'b1, 3);
        run(1'b0, F3_W, 32'h100, 32'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
